// File: rtl/time_keeper_alarm_if.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper_alarm_if
//  Description : Control and display bundle of the time-of-day keeper.
//                slave  - seen by the keeper (controls in, time/alarm out)
//                master - seen by the driver (controls out, time/alarm in)
//  Signals     : mode_i[1:0]     00 run, 01 set secs, 10 set mins, 11 set hours
//                alarm_sel_i     plus/minus edit the alarm in modes 10/11
//                plus_pulse_i    single-cycle increment request
//                minus_pulse_i   single-cycle decrement request
//                fmt12_i         12h display format
//                alarm_en_i      alarm armed (level)
//                snooze_i        single-cycle dismiss-and-snooze request
//                secs_o/mins_o/hours_o          binary time of day
//                hours_disp_o/pm_o              display hour and PM flag
//                alarm_mins_o/alarm_hours_o     alarm setting
//                alarm_active_o  alarm sounding
//                tick_1hz_o      one-cycle pulse per second
//  Revision    : 1.0 - initial release
// ============================================================================
interface time_keeper_alarm_if;
    logic [1:0] mode_i;
    logic       alarm_sel_i;
    logic       plus_pulse_i;
    logic       minus_pulse_i;
    logic       fmt12_i;
    logic       alarm_en_i;
    logic       snooze_i;
    logic [7:0] secs_o;
    logic [7:0] mins_o;
    logic [7:0] hours_o;
    logic [7:0] hours_disp_o;
    logic       pm_o;
    logic [7:0] alarm_mins_o;
    logic [7:0] alarm_hours_o;
    logic       alarm_active_o;
    logic       tick_1hz_o;

    modport slave (
        input  mode_i, alarm_sel_i, plus_pulse_i, minus_pulse_i,
               fmt12_i, alarm_en_i, snooze_i,
        output secs_o, mins_o, hours_o, hours_disp_o, pm_o,
               alarm_mins_o, alarm_hours_o, alarm_active_o, tick_1hz_o
    );

    modport master (
        output mode_i, alarm_sel_i, plus_pulse_i, minus_pulse_i,
               fmt12_i, alarm_en_i, snooze_i,
        input  secs_o, mins_o, hours_o, hours_disp_o, pm_o,
               alarm_mins_o, alarm_hours_o, alarm_active_o, tick_1hz_o
    );
endinterface
`default_nettype wire

// File: rtl/time_keeper_alarm.sv
`default_nettype none
// ============================================================================
//  Module      : time_keeper_alarm
//  Description : 24h time-of-day keeper with a 1 Hz divider, per-field set
//                mode, 12h display output and one alarm with snooze.
//  Ports       : clk      system clock, rising edge
//                reset_n  asynchronous active-low reset
//                bus      time_keeper_alarm_if.slave (controls in, time out)
//  Parameters  : CLK_HZ       clk cycles per second tick
//                ALARM_SECS   ticks the alarm sounds if not dismissed (>=1)
//                SNOOZE_MINS  minutes from snooze to re-fire (1..59)
//                ALARM_RST_H  alarm hour after reset (0..23)
//  Revision    : 1.0 - initial release
// ============================================================================
module time_keeper_alarm #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int ALARM_SECS  = 60,
    parameter int SNOOZE_MINS = 5,
    parameter int ALARM_RST_H = 6
) (
    input  wire logic            clk,
    input  wire logic            reset_n,
    time_keeper_alarm_if.slave   bus
);
    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam int ACT_W = $clog2(ALARM_SECS) + 1;
    localparam int SNZ_W = 12;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_HZ - 1);
    localparam logic [ACT_W-1:0] ACT_LAST = ACT_W'(ALARM_SECS - 1);
    localparam logic [SNZ_W-1:0] SNZ_LOAD = SNZ_W'(SNOOZE_MINS * 60);
    localparam logic [7:0]       AL_RST_H = 8'(ALARM_RST_H);

    logic [DIV_W-1:0] div_q,    div_d;
    logic [7:0]       secs_q,   secs_d;
    logic [7:0]       mins_q,   mins_d;
    logic [7:0]       hours_q,  hours_d;
    logic [7:0]       amins_q,  amins_d;
    logic [7:0]       ahours_q, ahours_d;
    logic             active_q, active_d;
    logic [ACT_W-1:0] act_cnt_q, act_cnt_d;
    logic             snz_pend_q, snz_pend_d;
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
    logic             tick_q;

    logic       run, tick, inc, dec, match;
    logic [7:0] nsecs, nmins, nhours;

    // Wrapping +1/-1 for a single field; no carry into neighbours.
    function automatic logic [7:0] step_field(input logic [7:0] v,
                                              input logic [7:0] maxv,
                                              input logic       up);
        if (up) return (v == maxv) ? 8'd0 : v + 8'd1;
        else    return (v == 8'd0) ? maxv : v - 8'd1;
    endfunction

    always_comb begin
        run  = (bus.mode_i == 2'b00);
        tick = run && (div_q == DIV_MAX);
        inc  = bus.plus_pulse_i & ~bus.minus_pulse_i;
        dec  = bus.minus_pulse_i & ~bus.plus_pulse_i;

        // Time one second ahead, used both for the run update and alarm match.
        nsecs  = (secs_q == 8'd59) ? 8'd0 : secs_q + 8'd1;
        nmins  = mins_q;
        nhours = hours_q;
        if (secs_q == 8'd59) begin
            nmins = (mins_q == 8'd59) ? 8'd0 : mins_q + 8'd1;
            if (mins_q == 8'd59)
                nhours = (hours_q == 8'd23) ? 8'd0 : hours_q + 8'd1;
        end
        match = (nhours == ahours_q) && (nmins == amins_q) && (nsecs == 8'd0);

        div_d    = (!run || tick) ? '0 : div_q + DIV_W'(1);
        secs_d   = secs_q;
        mins_d   = mins_q;
        hours_d  = hours_q;
        amins_d  = amins_q;
        ahours_d = ahours_q;

        if (tick) begin
            secs_d  = nsecs;
            mins_d  = nmins;
            hours_d = nhours;
        end else if (!run && (inc || dec)) begin
            case (bus.mode_i)
                2'b01: if (!bus.alarm_sel_i) secs_d = step_field(secs_q, 8'd59, inc);
                2'b10: if (bus.alarm_sel_i) amins_d = step_field(amins_q, 8'd59, inc);
                       else                 mins_d  = step_field(mins_q, 8'd59, inc);
                2'b11: if (bus.alarm_sel_i) ahours_d = step_field(ahours_q, 8'd23, inc);
                       else                 hours_d  = step_field(hours_q, 8'd23, inc);
                default: ;
            endcase
        end

        active_d   = active_q;
        act_cnt_d  = act_cnt_q;
        snz_pend_d = snz_pend_q;
        snz_cnt_d  = snz_cnt_q;

        if (!bus.alarm_en_i) begin
            active_d   = 1'b0;
            act_cnt_d  = '0;
            snz_pend_d = 1'b0;
            snz_cnt_d  = '0;
        end else if (bus.snooze_i && active_q) begin
            active_d   = 1'b0;
            act_cnt_d  = '0;
            snz_pend_d = 1'b1;
            snz_cnt_d  = SNZ_LOAD;
        end else if (tick) begin
            if (active_q) begin
                if (act_cnt_q == ACT_LAST) begin
                    active_d  = 1'b0;
                    act_cnt_d = '0;
                end else begin
                    act_cnt_d = act_cnt_q + ACT_W'(1);
                end
            end else begin
                // Snooze counts ticks while silent; the last one re-fires.
                if (match || (snz_pend_q && snz_cnt_q == SNZ_W'(1))) begin
                    active_d  = 1'b1;
                    act_cnt_d = '0;
                end
                if (snz_pend_q) begin
                    if (snz_cnt_q == SNZ_W'(1)) begin
                        snz_pend_d = 1'b0;
                        snz_cnt_d  = '0;
                    end else begin
                        snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q      <= '0;
            secs_q     <= 8'd0;
            mins_q     <= 8'd0;
            hours_q    <= 8'd0;
            amins_q    <= 8'd0;
            ahours_q   <= AL_RST_H;
            active_q   <= 1'b0;
            act_cnt_q  <= '0;
            snz_pend_q <= 1'b0;
            snz_cnt_q  <= '0;
            tick_q     <= 1'b0;
        end else begin
            div_q      <= div_d;
            secs_q     <= secs_d;
            mins_q     <= mins_d;
            hours_q    <= hours_d;
            amins_q    <= amins_d;
            ahours_q   <= ahours_d;
            active_q   <= active_d;
            act_cnt_q  <= act_cnt_d;
            snz_pend_q <= snz_pend_d;
            snz_cnt_q  <= snz_cnt_d;
            tick_q     <= tick;
        end
    end

    // 12h display: midnight shows 12, afternoon hours fold down by 12.
    always_comb begin
        bus.hours_disp_o = hours_q;
        if (bus.fmt12_i) begin
            if (hours_q == 8'd0)      bus.hours_disp_o = 8'd12;
            else if (hours_q > 8'd12) bus.hours_disp_o = hours_q - 8'd12;
        end
    end

    assign bus.pm_o           = bus.fmt12_i && (hours_q >= 8'd12);
    assign bus.secs_o         = secs_q;
    assign bus.mins_o         = mins_q;
    assign bus.hours_o        = hours_q;
    assign bus.alarm_mins_o   = amins_q;
    assign bus.alarm_hours_o  = ahours_q;
    assign bus.alarm_active_o = active_q;
    assign bus.tick_1hz_o     = tick_q;
endmodule
`default_nettype wire
